// File: rtl/mux16_arb_pkg.sv
// Shared types and sizes for the 16-lane round-robin mux arbiter.
// No logic or latency of its own; holds the FSM encoding and lane helpers.
// No backpressure here; the arbiter handles flow through req/done.
package mux16_arb_pkg;

    localparam int N_LANES = 16;
    localparam int SEL_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    function automatic logic [N_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] idx);
        return N_LANES'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Wrap-around priority search: first set req bit at or above ptr, 15 wraps to 0.
// Purely combinational, zero latency.
// No backpressure; any=0 when no lane requests.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [N_LANES-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [N_LANES-1:0] w_rot;
    logic [SEL_W-1:0]   w_off;

    // Rotate so that lane ptr lands on bit 0; the lowest set bit is then the winner.
    assign w_rot = (req >> ptr) | (req << (5'd16 - {1'b0, ptr}));

    always_comb begin
        w_off = '0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SEL_W'(k);
            end
        end
    end

    assign idx = ptr + w_off;
    assign any = |req;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner arbiter for a 16:1 data mux with a one-cycle break-before-make gap.
// Latency: grant one edge after request; owner-to-owner turnaround two edges.
// Backpressure: owner holds until done, its req drops, or HOLD_MAX forces release.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX   = 16,
    parameter int unsigned TIMEOUT_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LANES-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic [N_LANES-1:0] gnt,
    output logic               gnt_valid,
    output logic               timeout
);

    arb_state_t         r_state, w_state_nx;
    logic [SEL_W-1:0]   r_ptr, w_ptr_nx;
    logic [7:0]         r_cnt, w_cnt_nx;
    logic [SEL_W-1:0]   r_sel, w_sel_nx;
    logic [N_LANES-1:0] r_gnt, w_gnt_nx;
    logic               r_timeout, w_timeout_nx;

    logic [SEL_W-1:0]   w_idx;
    logic               w_any;
    logic               w_rel;
    logic               w_hold_exp;

    rr_pick16 u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_idx),
        .any (w_any)
    );

    assign w_rel      = done | ~req[r_sel];
    assign w_hold_exp = (TIMEOUT_EN != 0) && (r_cnt == 8'(HOLD_MAX - 1));

    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_cnt_nx     = r_cnt;
        w_sel_nx     = r_sel;
        w_gnt_nx     = r_gnt;
        w_timeout_nx = 1'b0;
        case (r_state)
            GRANT: begin
                if (w_rel || w_hold_exp) begin
                    w_state_nx   = GAP;
                    w_ptr_nx     = r_sel + 4'd1;
                    w_gnt_nx     = '0;
                    // A voluntary release in the same cycle wins over the forced one.
                    w_timeout_nx = w_hold_exp & ~w_rel;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                if (w_any) begin
                    w_state_nx = GRANT;
                    w_sel_nx   = w_idx;
                    w_gnt_nx   = lane_onehot(w_idx);
                    w_cnt_nx   = '0;
                end else begin
                    w_state_nx = IDLE;
                    w_gnt_nx   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_gnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_cnt     <= w_cnt_nx;
            r_sel     <= w_sel_nx;
            r_gnt     <= w_gnt_nx;
            r_timeout <= w_timeout_nx;
        end
    end

    assign sel       = r_sel;
    assign gnt       = r_gnt;
    assign gnt_valid = |r_gnt;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed scenarios plus random traffic against a lane-level model.
module tb_mux16_rr_arbiter;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic        timeout;

    always #5 clk = ~clk;

    mux16_rr_arbiter #(
        .HOLD_MAX   (HOLD),
        .TIMEOUT_EN (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the mux, where the search starts, how long it has held.
    int m_owner;
    int m_ptr;
    int m_held;
    int m_sel;
    bit m_timeout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_held    = 0;
        m_sel     = 0;
        m_timeout = 0;
    endtask

    task automatic model_edge();
        bit rel;
        bit forced;
        m_timeout = 0;
        if (m_owner >= 0) begin
            rel    = done || !req[m_owner];
            forced = (m_held + 1 >= HOLD);
            if (rel || forced) begin
                m_timeout = forced && !rel;
                m_ptr     = (m_owner + 1) % 16;
                m_owner   = -2;
            end else begin
                m_held++;
            end
        end else begin
            m_owner = -1;
            for (int k = 0; k < 16; k++) begin
                if (m_owner == -1 && req[(m_ptr + k) % 16]) begin
                    m_owner = (m_ptr + k) % 16;
                end
            end
            if (m_owner >= 0) begin
                m_sel  = m_owner;
                m_held = 0;
            end
        end
    endtask

    task automatic compare(input string tag);
        logic [15:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check_eq({tag, ".sel"}, 32'(sel), 32'(m_sel));
        check_eq({tag, ".vld"}, 32'(gnt_valid), 32'(m_owner >= 0));
        check_eq({tag, ".to"}, 32'(timeout), 32'(m_timeout));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        compare(tag);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare("rst_pulse");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int lanes14[3] = '{14, 0, 1};
    int seen[$];
    bit prev_vld;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();
        #12;
        check_eq("reset.gnt", 32'(gnt), 32'h0);
        check_eq("reset.sel", 32'(sel), 32'h0);
        check_eq("reset.vld", 32'(gnt_valid), 32'h0);
        check_eq("reset.to", 32'(timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester on lane 0: one-edge grant latency.
        req = 16'h0001;
        cycle("lane0");
        check_eq("lane0.gnt_const", 32'(gnt), 32'h0001);
        check_eq("lane0.vld_const", 32'(gnt_valid), 32'h1);
        done = 1'b1;
        cycle("lane0_rel");
        done = 1'b0;
        req  = '0;
        cycle("lane0_gap");
        cycle("lane0_idle");

        // Park ptr at 14 via lane 13, then expect 14, 0, 1 with a gap between each.
        req = 16'h2000;
        cycle("p13");
        check_eq("p13.sel_const", 32'(sel), 32'd13);
        req  = 16'h4003;
        done = 1'b1;
        cycle("p13_rel");
        done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("wrap_gnt");
            check_eq("wrap.order", 32'(sel), 32'(lanes14[i]));
            done = 1'b1;
            cycle("wrap_gap");
            check_eq("wrap.gap_gnt", 32'(gnt), 32'h0);
            done = 1'b0;
        end
        req = '0;
        cycle("wrap_end");
        cycle("wrap_idle");

        // All lanes requesting, done on every third grant cycle.
        pulse_reset();
        req = 16'hFFFF;
        prev_vld = 0;
        seen.delete();
        for (int c = 0; c < 200 && seen.size() < 17; c++) begin
            done = (m_owner >= 0 && m_held == 2);
            cycle("fair");
            if (gnt_valid && !prev_vld) seen.push_back(int'(sel));
            prev_vld = gnt_valid;
        end
        done = 1'b0;
        check_eq("fair.count", 32'(seen.size()), 32'd17);
        for (int k = 0; k < seen.size(); k++) begin
            check_eq("fair.order", 32'(seen[k]), 32'(k % 16));
        end
        req = '0;
        cycle("fair_end");
        cycle("fair_idle");

        // Lane 9 alone with done low: forced release after HOLD grant cycles.
        req = 16'h0200;
        cycle("to_gnt");
        for (int i = 0; i < HOLD - 1; i++) begin
            cycle("to_hold");
            check_eq("to.held_gnt", 32'(gnt), 32'h0200);
        end
        cycle("to_gap");
        check_eq("to.gap_gnt", 32'(gnt), 32'h0);
        check_eq("to.pulse", 32'(timeout), 32'h1);
        cycle("to_regnt");
        check_eq("to.regnt", 32'(gnt), 32'h0200);
        check_eq("to.pulse_end", 32'(timeout), 32'h0);

        // done coinciding with the last allowed cycle: release without timeout.
        for (int i = 0; i < HOLD - 1; i++) cycle("tie_hold");
        done = 1'b1;
        cycle("tie_rel");
        check_eq("tie.gnt", 32'(gnt), 32'h0);
        check_eq("tie.to", 32'(timeout), 32'h0);
        done = 1'b0;
        cycle("tie_regnt");
        // Same tie with req dropping instead of done.
        for (int i = 0; i < HOLD - 1; i++) cycle("tie2_hold");
        req = '0;
        cycle("tie2_rel");
        check_eq("tie2.to", 32'(timeout), 32'h0);
        cycle("tie2_idle");

        // Asynchronous reset in the middle of a lane 7 grant.
        req = 16'h0080;
        cycle("l7");
        check_eq("l7.sel", 32'(sel), 32'd7);
        cycle("l7_hold");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst.gnt", 32'(gnt), 32'h0);
        check_eq("arst.sel", 32'(sel), 32'h0);
        check_eq("arst.vld", 32'(gnt_valid), 32'h0);
        check_eq("arst.to", 32'(timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 16'h0081;
        cycle("arst_first");
        check_eq("arst.first_lane", 32'(sel), 32'd0);
        done = 1'b1;
        cycle("arst_rel");
        done = 1'b0;

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: req = 16'($urandom);
                1: req = 16'h1 << $urandom_range(0, 15);
                2: req = req;
                default: req = 16'hFFFF;
            endcase
            done = ($urandom_range(0, 3) == 0);
            cycle("rand");
            if (i % 211 == 100) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                compare("rand_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16: maximum cycles one grant may be held (legal range 2..255).
REQ-002 Parameter TIMEOUT_EN, default 1: 1 enables forced release at HOLD_MAX; 0 disables it.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port req, input, 16: request per mux data lane; bit i requests lane i.
REQ-006 Port done, input, 1: current owner releases the mux; sampled only in GRANT.
REQ-007 Port sel, output, 4: registered select driven to the 16:1 mux select input.
REQ-008 Port gnt, output, 16: registered one-hot grant; all-zero when no owner.
REQ-009 Port gnt_valid, output, 1: high exactly when gnt is non-zero.
REQ-010 Port timeout, output, 1: one-cycle pulse when a grant is force-released by HOLD_MAX.

Function
REQ-011 FSM states SHALL be IDLE, GRANT and GAP.
REQ-012 IDLE: if req != 0, the winner is the first set bit at or above ptr, searching upward with wrap 15->0; the next state is GRANT, with gnt = onehot(winner), sel = winner and gnt_valid = 1 at that edge (1-cycle latency).
REQ-013 IDLE with req == 0 SHALL remain in IDLE, with gnt = 0 and sel holding its last value.
REQ-014 GRANT: hold counter clears on entry and increments each cycle; gnt and sel SHALL remain stable while in GRANT.
REQ-015 GRANT exits to GAP on the first edge where done = 1, req[owner] = 0, or (TIMEOUT_EN and counter == HOLD_MAX-1).
REQ-016 GRANT exit SHALL set ptr = owner+1 mod 16 (15 wraps to 0), gnt = 0 and gnt_valid = 0.
REQ-017 timeout SHALL pulse for the single GAP cycle only when the exit cause is solely HOLD_MAX; done or req drop in the same cycle takes precedence and suppresses the pulse.
REQ-018 GAP lasts exactly one cycle with gnt = 0 and sel held, for break-before-make on the mux.
REQ-019 GAP arbitrates as in IDLE using the updated ptr: req != 0 goes to GRANT, otherwise IDLE.
REQ-020 Minimum owner-to-owner turnaround: release sampled at edge t, GAP during t..t+1, new grant visible after edge t+1.
REQ-021 A requester that deasserts before being granted is simply skipped; req changes during GRANT do not affect the owner.
REQ-022 Fairness: with all 16 requesting continuously, each lane is granted exactly once per 16 grants.

Reset
REQ-023 rst_n low SHALL immediately force state = IDLE, gnt = 0, gnt_valid = 0, sel = 0, timeout = 0, ptr = 0 and hold counter = 0.
REQ-024 Reset asserted mid-GRANT drops the grant without a GAP cycle or timeout pulse; the first arbitration after release starts from lane 0.

Structure
REQ-025 Shared package mux16_arb_pkg SHALL hold the state enum (IDLE, GRANT, GAP), N_LANES = 16 and SEL_W = 4.
REQ-026 Combinational sub-module rr_pick16 (inputs req[15:0] and ptr[3:0]; outputs idx[3:0] and any) SHALL implement the wrap-around search.
REQ-027 sel SHALL be a register, never a combinational decode of req.

Verification
REQ-028 Reset, then req = 16'h0001 -> after 1 edge gnt = 16'h0001, sel = 0, gnt_valid = 1.
REQ-029 ptr = 14, req = 16'h4003 -> grant order lane 14, 0, 1, each separated by one GAP cycle with gnt = 0.
REQ-030 req = 16'hFFFF held, done pulsed every 3rd GRANT cycle -> sel sequence 0..15 then 0, with no repeats within 16 grants.
REQ-031 HOLD_MAX = 4, single requester lane 9 held, done = 0 -> gnt drops after 4 GRANT cycles, timeout pulses once, lane 9 is re-granted after GAP.
REQ-032 done = 1 in the same cycle the counter reaches HOLD_MAX-1 -> release occurs and timeout stays 0.
REQ-033 rst_n asserted mid-GRANT on lane 7 -> gnt = 0 and sel = 0 immediately, without waiting for a clock; after release, req = 16'h0081 grants lane 0 first.
